// File: rtl/lpc_decode.sv
// LPC synthesis filter: rebuilds a frame from excitation and ORDER predictor taps, one MAC per cycle.
// Optional LPC_DECODE_SAT_EN clips results to the DW range; otherwise results wrap to DW bits.
module lpc_decode #(
  parameter int ORDER     = 10,
  parameter int FRAME_LEN = 160,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int FRAC      = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 a_wen,
  input  logic [3:0]           a_waddr,
  input  logic signed [CW-1:0] a_din,
  input  logic                 e_wen,
  input  logic [7:0]           e_waddr,
  input  logic signed [DW-1:0] e_din,
  output logic                 y_valid,
  output logic [7:0]           y_addr,
  output logic signed [DW-1:0] y_dout,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned AW = 2 * DW + 8;
  localparam int unsigned PW = CW + DW;
  localparam int unsigned KW = 4;
  localparam int unsigned NW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MAC,
    S_OUT,
    S_DONE
  } state_t;

  state_t state, next_state;

  logic signed [CW-1:0] a_mem [ORDER];
  logic signed [DW-1:0] e_mem [FRAME_LEN];
  logic signed [DW-1:0] hist  [ORDER];

  logic [NW-1:0]        n;
  logic [KW-1:0]        tap;
  logic signed [AW-1:0] acc;
  logic signed [PW-1:0] prod_c;
  logic signed [DW-1:0] y_next_c;

  // Coefficient and excitation RAMs; only writable while idle, never cleared.
  always_ff @(posedge clk) begin
    if (state == S_IDLE) begin
      if (a_wen && (a_waddr < KW'(ORDER))) begin
        a_mem[a_waddr] <= a_din;
      end
      if (e_wen && (e_waddr < NW'(FRAME_LEN))) begin
        e_mem[e_waddr] <= e_din;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_LOAD;
      S_LOAD: next_state = S_MAC;
      S_MAC:  if (tap == KW'(ORDER - 1)) next_state = S_OUT;
      S_OUT:  next_state = (n == NW'(FRAME_LEN - 1)) ? S_DONE : S_LOAD;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // tap indexes a[tap+1] against s[n-tap-1]
  always_comb begin
    prod_c = PW'(a_mem[tap]) * PW'(hist[tap]);
  end

`ifdef LPC_DECODE_SAT_EN
  localparam int unsigned RW = AW - FRAC;
  localparam logic signed [RW-1:0] RES_MAX = RW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [RW-1:0] RES_MIN = ~RES_MAX;

  logic signed [RW-1:0] res_c;

  always_comb begin
    res_c = RW'(acc >>> FRAC);
    if (res_c > RES_MAX) begin
      y_next_c = {1'b0, {(DW - 1){1'b1}}};
    end else if (res_c < RES_MIN) begin
      y_next_c = {1'b1, {(DW - 1){1'b0}}};
    end else begin
      y_next_c = res_c[DW-1:0];
    end
  end
`else
  // Floor shift then keep the low DW bits (two's-complement wrap).
  always_comb begin
    y_next_c = acc[FRAC +: DW];
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n       <= '0;
      tap     <= '0;
      acc     <= '0;
      y_valid <= 1'b0;
      y_addr  <= '0;
      y_dout  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      for (int i = 0; i < ORDER; i++) begin
        hist[i] <= '0;
      end
    end else begin
      y_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            n    <= '0;
          end
        end
        S_LOAD: begin
          acc <= AW'(e_mem[n]) <<< FRAC;
          tap <= '0;
        end
        S_MAC: begin
          acc <= acc + AW'(prod_c);
          if (tap != KW'(ORDER - 1)) begin
            tap <= tap + KW'(1);
          end
        end
        S_OUT: begin
          y_dout  <= y_next_c;
          y_addr  <= n;
          y_valid <= 1'b1;
          hist[0] <= y_next_c;
          for (int i = 1; i < ORDER; i++) begin
            hist[i] <= hist[i-1];
          end
          if (n != NW'(FRAME_LEN - 1)) begin
            n <= n + NW'(1);
          end
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_decode.sv
// Bench for lpc_decode: directed and random frames against an arithmetic model of the synthesis filter.
module tb_lpc_decode;

  localparam int P = 10;
  localparam int N = 160;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        a_wen;
  logic [3:0]  a_waddr;
  logic [15:0] a_din;
  logic        e_wen;
  logic [7:0]  e_waddr;
  logic [15:0] e_din;
  logic        y_valid;
  logic [7:0]  y_addr;
  logic [15:0] y_dout;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  int a_m [P];
  int e_m [N];
  int hist_m [P];
  int exp_y [N];
  int cap_y [N];
  int imp_y [N];

  lpc_decode dut (
    .clk(clk), .reset(reset), .start(start),
    .a_wen(a_wen), .a_waddr(a_waddr), .a_din(a_din),
    .e_wen(e_wen), .e_waddr(e_waddr), .e_din(e_din),
    .y_valid(y_valid), .y_addr(y_addr), .y_dout(y_dout),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // s[n] = narrow(floor((e[n]*4096 + sum a[k]*s[n-k]) / 4096)), history carried in hist_m
  function automatic void model_frame();
    longint acc, res;
    int y;
    for (int n = 0; n < N; n++) begin
      acc = longint'(e_m[n]) * 4096;
      for (int k = 0; k < P; k++) acc += longint'(a_m[k]) * longint'(hist_m[k]);
      res = acc >>> 12;
`ifdef LPC_DECODE_SAT_EN
      if (res > 32767) y = 32767;
      else if (res < -32768) y = -32768;
      else y = int'(res);
`else
      y = int'(shortint'(res));
`endif
      exp_y[n] = y;
      for (int k = P - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
      hist_m[0] = y;
    end
  endfunction

  task automatic write_a(input int idx, input int val);
    a_wen = 1'b1; a_waddr = 4'(idx); a_din = 16'(val);
    @(posedge clk); #1;
    a_wen = 1'b0;
    if (idx < P) a_m[idx] = int'(shortint'(val));
  endtask

  task automatic write_e(input int idx, input int val);
    e_wen = 1'b1; e_waddr = 8'(idx); e_din = 16'(val);
    @(posedge clk); #1;
    e_wen = 1'b0;
    if (idx < N) e_m[idx] = int'(shortint'(val));
  endtask

  task automatic load_all();
    for (int i = 0; i < P; i++) write_a(i, a_m[i]);
    for (int i = 0; i < N; i++) write_e(i, e_m[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < P; k++) hist_m[k] = 0;
  endtask

  task automatic set_impulse();
    for (int i = 0; i < P; i++) a_m[i] = 0;
    for (int i = 0; i < N; i++) e_m[i] = 0;
    e_m[0] = 'h0100;
  endtask

  // Runs one frame; optional mid-frame disturbance, abort by reset, or e[0] write alongside start.
  task automatic run_frame(input bit disturb, input int abort_at, input bit use_e0, input int e0_val);
    int nval, ndone, done_c, busy_gap;
    nval = 0; ndone = 0; done_c = 0; busy_gap = 0;
    if (use_e0) begin
      e_m[0] = int'(shortint'(e0_val));
      e_wen = 1'b1; e_waddr = 8'd0; e_din = 16'(e0_val);
    end
    model_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; e_wen = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int cyc = 1; cyc < 2200; cyc++) begin
      @(posedge clk); #1;
      if (disturb && cyc == 30) begin
        start = 1'b1; e_wen = 1'b1; e_waddr = 8'd5; e_din = 16'h7777;
      end
      if (disturb && cyc == 31) begin
        start = 1'b0; e_wen = 1'b0;
      end
      if (ndone == 0 && cyc < 1921 && !busy) busy_gap++;
      if (y_valid) begin
        if (nval == 0) chk("first_valid_cycle", cyc, 12);
        if (nval < N) begin
          chk("y_addr", y_addr, nval);
          chk("y_dout", int'(shortint'(y_dout)), exp_y[nval]);
          cap_y[nval] = int'(shortint'(y_dout));
        end
        if (nval == abort_at) begin
          reset = 1'b1;
          #1;
          chk("abort_valid", y_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_dout", y_dout, 0);
          chk("abort_addr", y_addr, 0);
          @(posedge clk); #1;
          reset = 1'b0;
          for (int k = 0; k < P; k++) hist_m[k] = 0;
          ndone = 0;
          for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done || y_valid || busy) ndone++;
          end
          chk("abort_quiet", ndone, 0);
          return;
        end
        nval++;
      end
      if (done) begin
        if (ndone == 0) begin
          chk("done_cycle", cyc, 1921);
          chk("busy_at_done", busy, 0);
          done_c = cyc;
        end
        ndone++;
      end
      if (ndone > 0 && cyc >= done_c + 20) break;
    end
    chk("valid_count", nval, N);
    chk("done_count", ndone, 1);
    chk("busy_gap", busy_gap, 0);
  endtask

  initial begin
    int mism;
    reset = 1'b1; start = 1'b0;
    a_wen = 1'b0; a_waddr = '0; a_din = '0;
    e_wen = 1'b0; e_waddr = '0; e_din = '0;
    for (int k = 0; k < P; k++) hist_m[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", y_valid, 0);
    chk("rst_addr", y_addr, 0);
    chk("rst_dout", y_dout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // impulse with zero predictor, plus out-of-range writes that must be ignored
    set_impulse();
    load_all();
    write_a(12, 'h1234);
    write_e(200, 'h5555);
    run_frame(0, -1, 0, 0);
    chk("imp_y0", cap_y[0], 'h0100);
    chk("imp_y1", cap_y[1], 0);
    chk("imp_y159", cap_y[159], 0);
    for (int i = 0; i < N; i++) imp_y[i] = cap_y[i];

    // geometric decay with a[1]=0.5
    a_m[0] = 'h0800;
    for (int i = 0; i < N; i++) e_m[i] = 0;
    e_m[0] = 'h1000;
    load_all();
    run_frame(0, -1, 0, 0);
    chk("half_y1", cap_y[1], 'h0800);
    chk("half_y11", cap_y[11], 2);
    chk("half_y12", cap_y[12], 1);
    chk("half_y13", cap_y[13], 0);

    // overflow with a[1]=1.0 and constant excitation
    a_m[0] = 'h1000;
    for (int i = 0; i < N; i++) e_m[i] = 'h4000;
    load_all();
    run_frame(0, -1, 0, 0);
    chk("ovf_y0", cap_y[0], 'h4000);
`ifdef LPC_DECODE_SAT_EN
    chk("ovf_y1", cap_y[1], 32767);
    chk("ovf_y159", cap_y[159], 32767);
`else
    chk("ovf_y1", cap_y[1], -32768);
    chk("ovf_y2", cap_y[2], -16384);
    chk("ovf_y3", cap_y[3], 0);
`endif

    // history carried from one frame into the next
    do_reset();
    a_m[0] = 'h0800;
    for (int i = 0; i < N; i++) e_m[i] = 0;
    e_m[159] = 'h1000;
    load_all();
    run_frame(0, -1, 0, 0);
    chk("carry_f1_y159", cap_y[159], 'h1000);
    write_e(159, 0);
    run_frame(0, -1, 0, 0);
    chk("carry_f2_y0", cap_y[0], 'h0800);
    chk("carry_f2_y1", cap_y[1], 'h0400);

    // random taps and excitation; e[0] written in the same cycle as start
    for (int i = 0; i < P; i++) a_m[i] = int'($urandom_range(0, 'hC00)) - 'h600;
    for (int i = 0; i < N; i++) e_m[i] = int'(shortint'($urandom));
    load_all();
    run_frame(0, -1, 1, int'($urandom_range(0, 'hFFFF)));

    // new random excitation with start and an e write injected while busy
    for (int i = 0; i < N; i++) e_m[i] = int'(shortint'($urandom));
    load_all();
    run_frame(1, -1, 0, 0);

    // reset at sample 50, then the impulse frame must reproduce the first run
    set_impulse();
    load_all();
    run_frame(0, 50, 0, 0);
    run_frame(0, -1, 0, 0);
    mism = 0;
    for (int i = 0; i < N; i++) if (cap_y[i] != imp_y[i]) mism++;
    chk("rerun_impulse", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
